async_sram_phy_timed: RTL and testbench

Next-generation external asynchronous SRAM PHY with a programmable access sequencer.
- Accepts one read or write request at a time over a valid/ready handshake.
- Sequences address setup, strobe width, hold and read-to-write turnaround from runtime timing config, so slower SRAMs are supported without controller changes.
- Every pad-facing output comes straight from a flop; pads are instantiated outside this block.
- Data width is generalised to any whole number of byte lanes.

---
 rtl/async_sram_phy_pkg.sv | 18 +
 rtl/sram_phy_timer.sv | 32 +++
 rtl/async_sram_phy_timed.sv | 197 +++++++++++++++++++
 tb/tb_async_sram_phy_timed.sv | 501 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_sram_phy_pkg.sv
// Shared definitions for the asynchronous SRAM PHY.
// Provides the access sequencer state type and the power-on timing defaults
// that the PHY loads into its latched timing registers while in reset.
package async_sram_phy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_TURN
  } phy_state_e;

  localparam int unsigned TIMING_SETUP_DEF  = 1;
  localparam int unsigned TIMING_STROBE_DEF = 1;
  localparam int unsigned TIMING_HOLD_DEF   = 0;

endpackage

// File: rtl/sram_phy_timer.sv
// Loadable down-counter that times each phase of an SRAM access.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   load        reload the counter with load_val this cycle
//   load_val    number of remaining cycles minus one for the phase being entered
//   done        counter has reached zero (last cycle of the current phase)
module sram_phy_timer #(
  parameter int unsigned W_TIMING = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [W_TIMING-1:0] load_val,
  output logic                done
);

  logic [W_TIMING-1:0] cnt;

  // Saturates at zero so an idle counter never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W_TIMING'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/async_sram_phy_timed.sv
// External asynchronous SRAM PHY with a programmable access sequencer.
// One read or write is accepted at a time; address setup, strobe width and
// hold are timed from configuration latched at accept, and reads end with a
// one-cycle bus turnaround. Every pad-facing output is a flop.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cfg_setup/strobe/hold       timing (setup cycles, strobe width-1, hold cycles)
//   req_valid/ready/write/addr/wdata/bmask   request handshake and payload
//   rsp_valid, rsp_rdata        one-cycle read-data pulse
//   padin_sram_dq               DQ pad input
//   padoe_sram_dq, padout_sram_dq            DQ pad enables / data
//   padout_sram_a, _cs_n, _oe_n, _we_n, _byte_n  SRAM control and address pads
module async_sram_phy_timed
  import async_sram_phy_pkg::*;
#(
  parameter int unsigned N_SRAM_A  = 18,
  parameter int unsigned N_SRAM_DQ = 16,
  parameter int unsigned W_TIMING  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [W_TIMING-1:0]    cfg_setup,
  input  logic [W_TIMING-1:0]    cfg_strobe,
  input  logic [W_TIMING-1:0]    cfg_hold,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [N_SRAM_A-1:0]    req_addr,
  input  logic [N_SRAM_DQ-1:0]   req_wdata,
  input  logic [N_SRAM_DQ/8-1:0] req_bmask,
  output logic                   rsp_valid,
  output logic [N_SRAM_DQ-1:0]   rsp_rdata,
  input  logic [N_SRAM_DQ-1:0]   padin_sram_dq,
  output logic [N_SRAM_DQ-1:0]   padoe_sram_dq,
  output logic [N_SRAM_DQ-1:0]   padout_sram_dq,
  output logic [N_SRAM_A-1:0]    padout_sram_a,
  output logic                   padout_sram_cs_n,
  output logic                   padout_sram_oe_n,
  output logic                   padout_sram_we_n,
  output logic [N_SRAM_DQ/8-1:0] padout_sram_byte_n
);

  localparam int unsigned N_LANE = N_SRAM_DQ / 8;

  phy_state_e            state_q, state_d;
  logic [W_TIMING-1:0]   strobe_cfg_q, strobe_cfg_d;
  logic [W_TIMING-1:0]   hold_cfg_q, hold_cfg_d;
  logic                  write_q, write_d;
  logic                  cs_n_d, oe_n_d, we_n_d;
  logic [N_LANE-1:0]     byte_n_d;
  logic [N_SRAM_DQ-1:0]  dq_oe_d, dq_out_d, rdata_d;
  logic [N_SRAM_A-1:0]   a_d;
  logic                  rsp_valid_d;
  logic                  finish;
  logic                  tmr_load;
  logic [W_TIMING-1:0]   tmr_val;
  logic                  tmr_done;

  sram_phy_timer #(
    .W_TIMING(W_TIMING)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  assign req_ready = (state_q == ST_IDLE);

  // Pad outputs are registered, so the comb process computes the value each
  // pad must take in the state being entered rather than the current one.
  always_comb begin
    state_d      = state_q;
    strobe_cfg_d = strobe_cfg_q;
    hold_cfg_d   = hold_cfg_q;
    write_d      = write_q;
    cs_n_d       = padout_sram_cs_n;
    oe_n_d       = padout_sram_oe_n;
    we_n_d       = padout_sram_we_n;
    byte_n_d     = padout_sram_byte_n;
    dq_oe_d      = padoe_sram_dq;
    dq_out_d     = padout_sram_dq;
    a_d          = padout_sram_a;
    rdata_d      = rsp_rdata;
    rsp_valid_d  = 1'b0;
    finish       = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          strobe_cfg_d = cfg_strobe;
          hold_cfg_d   = cfg_hold;
          write_d      = req_write;
          a_d          = req_addr;
          byte_n_d     = ~req_bmask;
          cs_n_d       = 1'b0;
          if (req_write) begin
            dq_out_d = req_wdata;
            dq_oe_d  = '1;
          end
          tmr_load = 1'b1;
          if (cfg_setup != '0) begin
            state_d = ST_SETUP;
            tmr_val = cfg_setup - W_TIMING'(1);
          end else begin
            state_d = ST_STROBE;
            tmr_val = cfg_strobe;
            oe_n_d  = req_write;
            we_n_d  = !req_write;
          end
        end
      end
      ST_SETUP: begin
        if (tmr_done) begin
          state_d  = ST_STROBE;
          tmr_load = 1'b1;
          tmr_val  = strobe_cfg_q;
          oe_n_d   = write_q;
          we_n_d   = !write_q;
        end
      end
      ST_STROBE: begin
        if (tmr_done) begin
          oe_n_d = 1'b1;
          we_n_d = 1'b1;
          if (!write_q) begin
            rsp_valid_d = 1'b1;
            rdata_d     = padin_sram_dq;
          end
          if (hold_cfg_q != '0) begin
            state_d  = ST_HOLD;
            tmr_load = 1'b1;
            tmr_val  = hold_cfg_q - W_TIMING'(1);
          end else begin
            finish = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (tmr_done) begin
          finish = 1'b1;
        end
      end
      ST_TURN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Shared exit from STROBE (zero hold) or HOLD: release the chip, stop
    // driving DQ, and send reads through the turnaround cycle.
    if (finish) begin
      cs_n_d   = 1'b1;
      byte_n_d = '1;
      dq_oe_d  = '0;
      state_d  = write_q ? ST_IDLE : ST_TURN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= ST_IDLE;
      strobe_cfg_q       <= W_TIMING'(TIMING_STROBE_DEF);
      hold_cfg_q         <= W_TIMING'(TIMING_HOLD_DEF);
      write_q            <= 1'b0;
      padout_sram_cs_n   <= 1'b1;
      padout_sram_oe_n   <= 1'b1;
      padout_sram_we_n   <= 1'b1;
      padout_sram_byte_n <= '1;
      padoe_sram_dq      <= '0;
      padout_sram_dq     <= '0;
      padout_sram_a      <= '0;
      rsp_valid          <= 1'b0;
      rsp_rdata          <= '0;
    end else begin
      state_q            <= state_d;
      strobe_cfg_q       <= strobe_cfg_d;
      hold_cfg_q         <= hold_cfg_d;
      write_q            <= write_d;
      padout_sram_cs_n   <= cs_n_d;
      padout_sram_oe_n   <= oe_n_d;
      padout_sram_we_n   <= we_n_d;
      padout_sram_byte_n <= byte_n_d;
      padoe_sram_dq      <= dq_oe_d;
      padout_sram_dq     <= dq_out_d;
      padout_sram_a      <= a_d;
      rsp_valid          <= rsp_valid_d;
      rsp_rdata          <= rdata_d;
    end
  end

endmodule

// File: tb/tb_async_sram_phy_timed.sv
// Self-checking bench for async_sram_phy_timed: a cycle-indexed reference
// model of one access (phase boundaries from S/P/H arithmetic) is compared
// against recorded pad activity for directed and randomized accesses, plus a
// second instance built with a 32-bit data bus.
module tb_async_sram_phy_timed;
  import async_sram_phy_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  cfg_setup, cfg_strobe, cfg_hold;
  logic        req_valid, req_ready, req_write;
  logic [17:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_bmask;
  logic        rsp_valid;
  logic [15:0] rsp_rdata, padin_sram_dq, padoe_sram_dq, padout_sram_dq;
  logic [17:0] padout_sram_a;
  logic        padout_sram_cs_n, padout_sram_oe_n, padout_sram_we_n;
  logic [1:0]  padout_sram_byte_n;

  logic        x_valid, x_ready, x_write, x_rsp_valid;
  logic [17:0] x_addr, x_a;
  logic [31:0] x_wdata, x_rdata, x_padin, x_padoe, x_padout;
  logic [3:0]  x_bmask, x_byte_n;
  logic        x_cs_n, x_oe_n, x_we_n;

  async_sram_phy_timed #(.N_SRAM_A(18), .N_SRAM_DQ(16), .W_TIMING(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_setup(cfg_setup), .cfg_strobe(cfg_strobe), .cfg_hold(cfg_hold),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_bmask(req_bmask),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .padin_sram_dq(padin_sram_dq), .padoe_sram_dq(padoe_sram_dq),
    .padout_sram_dq(padout_sram_dq), .padout_sram_a(padout_sram_a),
    .padout_sram_cs_n(padout_sram_cs_n), .padout_sram_oe_n(padout_sram_oe_n),
    .padout_sram_we_n(padout_sram_we_n), .padout_sram_byte_n(padout_sram_byte_n)
  );

  async_sram_phy_timed #(.N_SRAM_A(18), .N_SRAM_DQ(32), .W_TIMING(4)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .cfg_setup(cfg_setup), .cfg_strobe(cfg_strobe), .cfg_hold(cfg_hold),
    .req_valid(x_valid), .req_ready(x_ready), .req_write(x_write),
    .req_addr(x_addr), .req_wdata(x_wdata), .req_bmask(x_bmask),
    .rsp_valid(x_rsp_valid), .rsp_rdata(x_rdata),
    .padin_sram_dq(x_padin), .padoe_sram_dq(x_padoe),
    .padout_sram_dq(x_padout), .padout_sram_a(x_a),
    .padout_sram_cs_n(x_cs_n), .padout_sram_oe_n(x_oe_n),
    .padout_sram_we_n(x_we_n), .padout_sram_byte_n(x_byte_n)
  );

  typedef struct packed {
    logic        ready;
    logic        cs_n;
    logic        oe_n;
    logic        we_n;
    logic [1:0]  byte_n;
    logic [15:0] dq_oe;
    logic [17:0] a;
    logic        rsp_valid;
  } obs_t;

  typedef struct {
    bit          wr;
    int          s;
    int          p;
    int          h;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [1:0]  bmask;
  } req_t;

  int compared = 0;
  int mismatched = 0;

  obs_t        obs_rec   [0:255];
  logic [15:0] rdata_rec [0:255];
  logic [15:0] dqout_rec [0:255];
  logic [15:0] padin_rec [0:255];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic req_t mk_req(input bit wr, input int s, input int p, input int h,
                                  input logic [17:0] addr, input logic [15:0] wdata,
                                  input logic [1:0] bmask);
    req_t r;
    r.wr = wr; r.s = s; r.p = p; r.h = h;
    r.addr = addr; r.wdata = wdata; r.bmask = bmask;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.wr    = 1'($urandom);
    r.s     = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
    r.p     = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
    r.h     = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
    r.addr  = 18'($urandom);
    r.wdata = 16'($urandom);
    r.bmask = 2'($urandom);
    return r;
  endfunction

  // Total access length counted from the accept cycle to the first idle cycle.
  function automatic int acc_len(input req_t r);
    return 1 + r.s + (r.p + 1) + r.h + (r.wr ? 0 : 1);
  endfunction

  // Expected pads in cycle k after the accept edge (k = 1 is the first cycle).
  function automatic void expect_at(input req_t r, input int k, output obs_t e, output bit dq_chk);
    int strobe_end;
    int hold_end;
    strobe_end  = r.s + r.p + 1;
    hold_end    = strobe_end + r.h;
    e.ready     = (k == acc_len(r));
    e.cs_n      = 1'b1;
    e.oe_n      = 1'b1;
    e.we_n      = 1'b1;
    e.byte_n    = 2'b11;
    e.dq_oe     = 16'h0000;
    e.a         = r.addr;
    e.rsp_valid = !r.wr && (k == strobe_end + 1);
    if (k <= hold_end) begin
      e.cs_n   = 1'b0;
      e.byte_n = ~r.bmask;
      e.dq_oe  = r.wr ? 16'hFFFF : 16'h0000;
      if (k > r.s && k <= strobe_end) begin
        e.oe_n = r.wr;
        e.we_n = !r.wr;
      end
    end
    dq_chk = r.wr && (k <= hold_end);
  endfunction

  function automatic void exp_glob(input req_t r0, input bit two, input req_t r1, input int l0,
                                   input int k, output obs_t e, output bit dq_chk,
                                   output logic [15:0] wd);
    if (two && k > l0) begin
      expect_at(r1, k - l0, e, dq_chk);
      wd = r1.wdata;
    end else begin
      expect_at(r0, k, e, dq_chk);
      wd = r0.wdata;
    end
  endfunction

  function automatic obs_t sample_obs();
    obs_t o;
    o.ready = req_ready; o.cs_n = padout_sram_cs_n; o.oe_n = padout_sram_oe_n;
    o.we_n = padout_sram_we_n; o.byte_n = padout_sram_byte_n; o.dq_oe = padoe_sram_dq;
    o.a = padout_sram_a; o.rsp_valid = rsp_valid;
    return o;
  endfunction

  task automatic drive_req(input req_t r);
    req_write  = r.wr;
    req_addr   = r.addr;
    req_wdata  = r.wdata;
    req_bmask  = r.bmask;
    cfg_setup  = 4'(r.s);
    cfg_strobe = 4'(r.p);
    cfg_hold   = 4'(r.h);
  endtask

  // Issues r0 (and, if two, r1 with valid held high throughout) and records
  // the pads for every cycle after the first accept edge.
  task automatic run(input req_t r0, input bit two, input req_t r1, input int chg_k,
                     input int chg_p, input bit fixed_in, input logic [15:0] in_val,
                     output int total, output int l0);
    int waited;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 64) begin
      step();
      waited++;
    end
    compared++;
    if (req_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL ready_wait: req_ready=%b required 1 within 64 cycles", req_ready);
    end
    l0    = acc_len(r0);
    total = l0 + (two ? acc_len(r1) : 0);
    drive_req(r0);
    req_valid     = 1'b1;
    padin_sram_dq = fixed_in ? in_val : 16'($urandom);
    for (int k = 1; k <= total; k++) begin
      step();
      obs_rec[k]   = sample_obs();
      rdata_rec[k] = rsp_rdata;
      dqout_rec[k] = padout_sram_dq;
      if (k == 1) begin
        if (two) drive_req(r1);
        else req_valid = 1'b0;
      end
      if (two && k == l0 + 1) req_valid = 1'b0;
      if (k == chg_k) begin
        cfg_strobe = 4'(chg_p);
        cfg_setup  = 4'($urandom);
        cfg_hold   = 4'($urandom);
      end
      padin_sram_dq = fixed_in ? in_val : 16'($urandom);
      padin_rec[k]  = padin_sram_dq;
    end
  endtask

  task automatic test_reset();
    logic [71:0] got;
    logic [71:0] want;
    want = {3'b111, 2'b11, 16'h0, 16'h0, 18'h0, 1'b0, 16'h0};
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'($urandom); req_write = 1'($urandom); req_addr = 18'($urandom);
      req_wdata = 16'($urandom); req_bmask = 2'($urandom); padin_sram_dq = 16'($urandom);
      cfg_setup = 4'($urandom); cfg_strobe = 4'($urandom); cfg_hold = 4'($urandom);
      x_valid = 1'($urandom); x_padin = $urandom;
      step();
      got = {padout_sram_cs_n, padout_sram_oe_n, padout_sram_we_n, padout_sram_byte_n,
             padoe_sram_dq, padout_sram_dq, padout_sram_a, rsp_valid, rsp_rdata};
      compared++;
      if (got !== want) begin
        mismatched++;
        $display("FAIL reset_pads cyc %0d: got %h required %h", i, got, want);
      end
      compared++;
      if ({x_cs_n, x_oe_n, x_we_n, x_byte_n, x_padoe, x_rsp_valid} !== {3'b111, 4'hF, 32'h0, 1'b0}) begin
        mismatched++;
        $display("FAIL reset_pads32 cyc %0d: cs_n=%b oe_n=%b we_n=%b byte_n=%b oe=%h rsp=%b required 1 1 1 1111 0 0",
                 i, x_cs_n, x_oe_n, x_we_n, x_byte_n, x_padoe, x_rsp_valid);
      end
    end
    req_valid = 1'b0; x_valid = 1'b0;
    cfg_setup = 4'(TIMING_SETUP_DEF); cfg_strobe = 4'(TIMING_STROBE_DEF); cfg_hold = 4'(TIMING_HOLD_DEF);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    compared++;
    if (req_ready !== 1'b1 || padout_sram_cs_n !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_release: ready=%b cs_n=%b required 1 1", req_ready, padout_sram_cs_n);
    end
  endtask

  task automatic test_timed_read();
    req_t r;
    obs_t e;
    bit dqc;
    logic [15:0] wd;
    int total, l0;
    r = mk_req(1'b0, 1, 1, 0, 18'h12345, 16'h0000, 2'b11);
    run(r, 1'b0, r, -1, 0, 1'b1, 16'hBEEF, total, l0);
    for (int k = 1; k <= total; k++) begin
      exp_glob(r, 1'b0, r, l0, k, e, dqc, wd);
      compared++;
      if (obs_rec[k] !== e) begin
        mismatched++;
        $display("FAIL timed_read cyc %0d: pads %h required %h", k, obs_rec[k], e);
      end
    end
    compared++;
    if (obs_rec[4].rsp_valid !== 1'b1 || rdata_rec[4] !== 16'hBEEF) begin
      mismatched++;
      $display("FAIL timed_read_data: rsp_valid=%b rdata=%h required 1 beef", obs_rec[4].rsp_valid, rdata_rec[4]);
    end
  endtask

  task automatic test_masked_write();
    req_t r;
    obs_t e;
    bit dqc;
    logic [15:0] wd;
    int total, l0;
    r = mk_req(1'b1, 0, 2, 1, 18'h00ABC, 16'hA55A, 2'b10);
    run(r, 1'b0, r, -1, 0, 1'b0, 16'h0, total, l0);
    for (int k = 1; k <= total; k++) begin
      exp_glob(r, 1'b0, r, l0, k, e, dqc, wd);
      compared++;
      if (obs_rec[k] !== e) begin
        mismatched++;
        $display("FAIL masked_write cyc %0d: pads %h required %h", k, obs_rec[k], e);
      end
      if (dqc) begin
        compared++;
        if (dqout_rec[k] !== wd) begin
          mismatched++;
          $display("FAIL masked_write_dq cyc %0d: dq_out %h required %h", k, dqout_rec[k], wd);
        end
      end
    end
  endtask

  task automatic test_random(input int n);
    req_t r;
    obs_t e;
    bit dqc;
    logic [15:0] wd;
    int total, l0;
    for (int i = 0; i < n; i++) begin
      r = rand_req();
      if (i == 0) begin
        r.s = 15; r.p = 15; r.h = 15;
      end
      if (i == 1) begin
        r.s = 0; r.p = 0; r.h = 0;
      end
      run(r, 1'b0, r, -1, 0, 1'b0, 16'h0, total, l0);
      for (int k = 1; k <= total; k++) begin
        exp_glob(r, 1'b0, r, l0, k, e, dqc, wd);
        compared++;
        if (obs_rec[k] !== e) begin
          mismatched++;
          $display("FAIL random[%0d] wr=%0d S=%0d P=%0d H=%0d cyc %0d: pads %h required %h",
                   i, r.wr, r.s, r.p, r.h, k, obs_rec[k], e);
        end
        if (e.rsp_valid) begin
          compared++;
          if (rdata_rec[k] !== padin_rec[k-1]) begin
            mismatched++;
            $display("FAIL random_rdata[%0d]: rdata %h required %h", i, rdata_rec[k], padin_rec[k-1]);
          end
        end
        if (dqc) begin
          compared++;
          if (dqout_rec[k] !== wd) begin
            mismatched++;
            $display("FAIL random_dq[%0d] cyc %0d: dq_out %h required %h", i, k, dqout_rec[k], wd);
          end
        end
      end
      for (int g = $urandom_range(0, 2); g > 0; g--) step();
    end
  endtask

  task automatic test_back_to_back();
    req_t r0, r1;
    obs_t e;
    bit dqc;
    logic [15:0] wd;
    int total, l0;
    r0 = mk_req(1'b0, 1, 1, 0, 18'($urandom), 16'h0, 2'b11);
    r1 = mk_req(1'b1, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 2)), 18'($urandom), 16'($urandom), 2'b11);
    run(r0, 1'b1, r1, -1, 0, 1'b0, 16'h0, total, l0);
    for (int k = 1; k <= total; k++) begin
      exp_glob(r0, 1'b1, r1, l0, k, e, dqc, wd);
      compared++;
      if (obs_rec[k] !== e) begin
        mismatched++;
        $display("FAIL back_to_back cyc %0d: pads %h required %h", k, obs_rec[k], e);
      end
      if (e.rsp_valid) begin
        compared++;
        if (rdata_rec[k] !== padin_rec[k-1]) begin
          mismatched++;
          $display("FAIL back_to_back_rdata: rdata %h required %h", rdata_rec[k], padin_rec[k-1]);
        end
      end
      if (dqc) begin
        compared++;
        if (dqout_rec[k] !== wd) begin
          mismatched++;
          $display("FAIL back_to_back_dq cyc %0d: dq_out %h required %h", k, dqout_rec[k], wd);
        end
      end
      compared++;
      if (obs_rec[k].oe_n === 1'b0 && obs_rec[k].dq_oe !== 16'h0) begin
        mismatched++;
        $display("FAIL bus_contention cyc %0d: dq_oe %h while oe_n=0, required 0000", k, obs_rec[k].dq_oe);
      end
    end
  endtask

  task automatic test_cfg_change();
    req_t r;
    obs_t e;
    bit dqc;
    logic [15:0] wd;
    int total, l0;
    for (int pass = 0; pass < 2; pass++) begin
      r = mk_req(1'($urandom), 1, (pass == 0) ? 1 : 7, 0, 18'($urandom), 16'($urandom), 2'b11);
      // first pass moves cfg_strobe to 7 in the first strobe cycle
      run(r, 1'b0, r, (pass == 0) ? 2 : -1, 7, 1'b0, 16'h0, total, l0);
      for (int k = 1; k <= total; k++) begin
        exp_glob(r, 1'b0, r, l0, k, e, dqc, wd);
        compared++;
        if (obs_rec[k] !== e) begin
          mismatched++;
          $display("FAIL cfg_change pass %0d cyc %0d: pads %h required %h", pass, k, obs_rec[k], e);
        end
      end
    end
  endtask

  task automatic test_reset_mid_write();
    req_t r;
    r = mk_req(1'b1, 0, 3, 2, 18'($urandom), 16'($urandom), 2'b11);
    drive_req(r);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    compared++;
    if (padout_sram_we_n !== 1'b0 || padoe_sram_dq !== 16'hFFFF) begin
      mismatched++;
      $display("FAIL reset_mid_write_pre: we_n=%b dq_oe=%h required 0 ffff", padout_sram_we_n, padoe_sram_dq);
    end
    rst_n = 1'b0;
    #1;
    compared++;
    if ({padout_sram_we_n, padout_sram_cs_n, padout_sram_oe_n, padout_sram_byte_n, padoe_sram_dq,
         padout_sram_dq, padout_sram_a, rsp_valid} !== {3'b111, 2'b11, 16'h0, 16'h0, 18'h0, 1'b0}) begin
      mismatched++;
      $display("FAIL reset_mid_write: we_n=%b cs_n=%b oe_n=%b byte_n=%b oe=%h dq=%h a=%h rsp=%b required 1 1 1 11 0 0 0 0",
               padout_sram_we_n, padout_sram_cs_n, padout_sram_oe_n, padout_sram_byte_n,
               padoe_sram_dq, padout_sram_dq, padout_sram_a, rsp_valid);
    end
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      compared++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || padout_sram_cs_n !== 1'b1) begin
        mismatched++;
        $display("FAIL reset_mid_write_after cyc %0d: rsp_valid=%b ready=%b cs_n=%b required 0 1 1",
                 i, rsp_valid, req_ready, padout_sram_cs_n);
      end
    end
  endtask

  task automatic test_dq32();
    logic [31:0] wdat, rdat;
    wdat = $urandom;
    rdat = $urandom;
    cfg_setup = 4'd0; cfg_strobe = 4'd0; cfg_hold = 4'd0;
    x_write = 1'b1; x_addr = 18'($urandom); x_wdata = wdat; x_bmask = 4'b0101; x_valid = 1'b1;
    step();
    x_valid = 1'b0;
    compared++;
    if (x_byte_n !== 4'b1010 || x_we_n !== 1'b0 || x_padoe !== 32'hFFFF_FFFF || x_padout !== wdat) begin
      mismatched++;
      $display("FAIL dq32_write: byte_n=%b we_n=%b oe=%h dq=%h required 1010 0 ffffffff %h",
               x_byte_n, x_we_n, x_padoe, x_padout, wdat);
    end
    step();
    compared++;
    if (x_ready !== 1'b1 || x_padoe !== 32'h0 || x_cs_n !== 1'b1) begin
      mismatched++;
      $display("FAIL dq32_write_end: ready=%b oe=%h cs_n=%b required 1 0 1", x_ready, x_padoe, x_cs_n);
    end
    x_write = 1'b0; x_bmask = 4'b1111; x_padin = rdat; x_valid = 1'b1;
    step();
    x_valid = 1'b0;
    compared++;
    if (x_oe_n !== 1'b0 || x_padoe !== 32'h0) begin
      mismatched++;
      $display("FAIL dq32_read_strobe: oe_n=%b oe=%h required 0 0", x_oe_n, x_padoe);
    end
    step();
    x_padin = ~rdat;
    compared++;
    if (x_rsp_valid !== 1'b1 || x_rdata !== rdat) begin
      mismatched++;
      $display("FAIL dq32_read_data: rsp_valid=%b rdata=%h required 1 %h", x_rsp_valid, x_rdata, rdat);
    end
    step();
    compared++;
    if (x_ready !== 1'b1 || x_rsp_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL dq32_read_end: ready=%b rsp_valid=%b required 1 0", x_ready, x_rsp_valid);
    end
  endtask

  initial begin
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_bmask = '0;
    padin_sram_dq = '0;
    cfg_setup = 4'(TIMING_SETUP_DEF); cfg_strobe = 4'(TIMING_STROBE_DEF); cfg_hold = 4'(TIMING_HOLD_DEF);
    x_valid = 1'b0; x_write = 1'b0; x_addr = '0; x_wdata = '0; x_bmask = '0; x_padin = '0;
    test_reset();
    test_timed_read();
    test_masked_write();
    test_back_to_back();
    test_cfg_change();
    test_random(30);
    test_reset_mid_write();
    test_dq32();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
